// File: rtl/axi_slave_arb_b.sv
// B-channel response collector: round-robin over three slave ports into a
// single registered output slot feeding the master demux.
module axi_slave_arb_b #(
    parameter int ID_W   = 8,
    parameter int RESP_W = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   s0_BID,
    input  logic [RESP_W-1:0] s0_BRESP,
    input  logic              s0_BVALID,
    output logic              s0_BREADY,
    input  logic [ID_W-1:0]   s1_BID,
    input  logic [RESP_W-1:0] s1_BRESP,
    input  logic              s1_BVALID,
    output logic              s1_BREADY,
    input  logic [ID_W-1:0]   s2_BID,
    input  logic [RESP_W-1:0] s2_BRESP,
    input  logic              s2_BVALID,
    output logic              s2_BREADY,
    output logic [ID_W-1:0]   bid,
    output logic [RESP_W-1:0] bresp,
    output logic              bvalid,
    input  logic              bready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic [1:0]        last_gnt;
    logic [1:0]        gnt_idx;
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic              load_ok;
    logic              load;
    logic [ID_W-1:0]   sel_id;
    logic [RESP_W-1:0] sel_resp;

    assign req     = {s2_BVALID, s1_BVALID, s0_BVALID};
    assign bvalid  = (state == FULL);
    // armed keeps every BREADY low in the first cycle after reset release
    assign load_ok = armed & (!bvalid | bready);
    assign load    = |gnt;

    assign s0_BREADY = gnt[0];
    assign s1_BREADY = gnt[1];
    assign s2_BREADY = gnt[2];

    always_comb begin
        gnt = 3'b000;
        if (load_ok) begin
            case (last_gnt)
                2'd0: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd1: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        gnt_idx  = 2'd0;
        sel_id   = s0_BID;
        sel_resp = s0_BRESP;
        if (gnt[1]) begin
            gnt_idx  = 2'd1;
            sel_id   = s1_BID;
            sel_resp = s1_BRESP;
        end else if (gnt[2]) begin
            gnt_idx  = 2'd2;
            sel_id   = s2_BID;
            sel_resp = s2_BRESP;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (load) state_nxt = FULL;
            end
            FULL: begin
                if (!load && bready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= EMPTY;
            armed    <= 1'b0;
            last_gnt <= 2'd2;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (load) last_gnt <= gnt_idx;
        end
    end

    // Slot payload only moves on a handshake, so it is stable during stalls
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bid   <= '0;
            bresp <= '0;
        end else if (load) begin
            bid   <= sel_id;
            bresp <= sel_resp;
        end
    end

endmodule
